// File: rtl/hazard_pkg.sv
// Shared state encoding and default sizing for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } pipe_state_t;

    localparam int REG_W_DEF        = 5;
    localparam int MEM_TIMEOUT_DEF  = 64;
    localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags an ID-stage source operand that depends on a
// load still sitting in EXE, so the consumer must wait one cycle.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] i_id_src1,
    input  logic [REG_W-1:0] i_id_src2,
    input  logic             i_id_src1_used,
    input  logic             i_id_src2_used,
    input  logic [REG_W-1:0] i_ex_dest,
    input  logic             i_ex_reg_write,
    input  logic             i_ex_mem_to_reg,
    output logic             o_load_use
);

    logic w_ex_load;
    logic w_src1_hit;
    logic w_src2_hit;

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_ex_load  = i_ex_mem_to_reg & i_ex_reg_write & (i_ex_dest != '0);
    assign w_src1_hit = i_id_src1_used & (i_id_src1 == i_ex_dest);
    assign w_src2_hit = i_id_src2_used & (i_id_src2 == i_ex_dest);
    assign o_load_use = w_ex_load & (w_src1_hit | w_src2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Global stall/flush sequencer: turns load-use, cache-stall, jump and halt
// events into freeze/bubble/flush controls for the pipeline registers.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W        = REG_W_DEF,
    parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_src1_used,
    input  logic             id_src2_used,
    input  logic             id_halted,
    input  logic [REG_W-1:0] ex_dest_reg_num,
    input  logic             ex_reg_write,
    input  logic             ex_mem_to_reg,
    input  logic             ex_jump_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_exe_freeze,
    output logic             id_exe_bubble,
    output logic             exe_mem_freeze,
    output logic             mem_timeout,
    output logic             halted
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

    pipe_state_t        r_state;
    pipe_state_t        r_ret_state;
    pipe_state_t        w_next_state;
    pipe_state_t        w_next_ret;
    pipe_state_t        w_eff_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [WAIT_W-1:0]  w_wait_cnt_nxt;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [DRAIN_W-1:0] w_drain_cnt_nxt;
    logic [DRAIN_W-1:0] w_drain_inc;
    logic               r_mem_timeout;
    logic               w_mem_stall;
    logic               w_load_use;
    logic               w_pc_freeze;
    logic               w_if_id_freeze;
    logic               w_if_id_flush;
    logic               w_id_exe_freeze;
    logic               w_id_exe_bubble;
    logic               w_exe_mem_freeze;
    logic               w_halted;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .i_id_src1       (id_src1),
        .i_id_src2       (id_src2),
        .i_id_src1_used  (id_src1_used),
        .i_id_src2_used  (id_src2_used),
        .i_ex_dest       (ex_dest_reg_num),
        .i_ex_reg_write  (ex_reg_write),
        .i_ex_mem_to_reg (ex_mem_to_reg),
        .o_load_use      (w_load_use)
    );

    assign w_mem_stall = mem_req & ~mem_ready;
    assign w_drain_inc = r_drain_cnt + DRAIN_ONE;

    // Next-state, counter and pipeline-control decode.
    always_comb begin
        w_pc_freeze      = 1'b0;
        w_if_id_freeze   = 1'b0;
        w_if_id_flush    = 1'b0;
        w_id_exe_freeze  = 1'b0;
        w_id_exe_bubble  = 1'b0;
        w_exe_mem_freeze = 1'b0;
        w_halted         = 1'b0;
        w_next_state     = r_state;
        w_next_ret       = r_ret_state;
        w_wait_cnt_nxt   = '0;
        w_drain_cnt_nxt  = r_drain_cnt;
        // A MEM_WAIT cycle whose access completes already acts as the state it returns to.
        if ((r_state == MEM_WAIT) && !w_mem_stall) begin
            w_eff_state = r_ret_state;
        end else begin
            w_eff_state = r_state;
        end
        case (w_eff_state)
            RUN: begin
                if (w_mem_stall) begin
                    {w_pc_freeze, w_if_id_freeze, w_id_exe_freeze, w_exe_mem_freeze} = 4'b1111;
                    w_next_state   = MEM_WAIT;
                    w_next_ret     = RUN;
                    w_wait_cnt_nxt = WAIT_ONE;
                end else if (ex_jump_taken) begin
                    w_if_id_flush   = 1'b1;
                    w_id_exe_bubble = 1'b1;
                    w_next_state    = RUN;
                end else if (w_load_use) begin
                    w_pc_freeze     = 1'b1;
                    w_if_id_freeze  = 1'b1;
                    w_id_exe_bubble = 1'b1;
                    w_next_state    = RUN;
                end else if (id_halted) begin
                    w_pc_freeze     = 1'b1;
                    w_if_id_freeze  = 1'b1;
                    w_next_state    = DRAIN;
                    w_drain_cnt_nxt = '0;
                end else begin
                    w_next_state = RUN;
                end
            end
            MEM_WAIT: begin
                {w_pc_freeze, w_if_id_freeze, w_id_exe_freeze, w_exe_mem_freeze} = 4'b1111;
                if (r_wait_cnt != WAIT_LIMIT) begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_ONE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt;
                end
            end
            DRAIN: begin
                if (w_mem_stall) begin
                    {w_pc_freeze, w_if_id_freeze, w_id_exe_freeze, w_exe_mem_freeze} = 4'b1111;
                    w_next_state   = MEM_WAIT;
                    w_next_ret     = DRAIN;
                    w_wait_cnt_nxt = WAIT_ONE;
                end else begin
                    w_pc_freeze     = 1'b1;
                    w_if_id_freeze  = 1'b1;
                    w_id_exe_bubble = 1'b1;
                    w_drain_cnt_nxt = w_drain_inc;
                    // Halted asserts DRAIN_CYCLES unstalled cycles after the halt left ID.
                    if (w_drain_inc >= DRAIN_LAST) begin
                        w_next_state = HALTED;
                    end else begin
                        w_next_state = DRAIN;
                    end
                end
            end
            HALTED: begin
                {w_pc_freeze, w_if_id_freeze, w_id_exe_freeze, w_exe_mem_freeze} = 4'b1111;
                w_halted     = 1'b1;
                w_next_state = HALTED;
            end
            default: begin
                w_next_state = RUN;
                w_next_ret   = RUN;
            end
        endcase
    end

    // Pipeline state, wait/drain counters and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state       <= RUN;
            r_ret_state   <= RUN;
            r_wait_cnt    <= '0;
            r_drain_cnt   <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            if ((r_state == MEM_WAIT) && (r_wait_cnt == WAIT_LIMIT)) begin
                r_mem_timeout <= 1'b1;
            end else begin
                r_mem_timeout <= r_mem_timeout;
            end
        end
    end

    // Controls are forced inactive for as long as reset is held.
    assign pc_freeze      = rst_b & w_pc_freeze;
    assign if_id_freeze   = rst_b & w_if_id_freeze;
    assign if_id_flush    = rst_b & w_if_id_flush;
    assign id_exe_freeze  = rst_b & w_id_exe_freeze;
    assign id_exe_bubble  = rst_b & w_id_exe_bubble;
    assign exe_mem_freeze = rst_b & w_exe_mem_freeze;
    assign mem_timeout    = r_mem_timeout;
    assign halted         = rst_b & w_halted;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with fixed expectations
// plus a randomized run, every cycle compared against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W        = 5;
    localparam int MEM_TIMEOUT  = 64;
    localparam int DRAIN_CYCLES = 3;

    // Bit order: pc_f, if_id_f, if_id_flush, id_exe_f, id_exe_bubble, exe_mem_f, timeout, halted
    localparam logic [7:0] NONE_V    = 8'b0000_0000;
    localparam logic [7:0] LU_V      = 8'b1100_1000;
    localparam logic [7:0] STALL_V   = 8'b1101_0100;
    localparam logic [7:0] JUMP_V    = 8'b0010_1000;
    localparam logic [7:0] HALTDET_V = 8'b1100_0000;
    localparam logic [7:0] DRAIN_V   = 8'b1100_1000;
    localparam logic [7:0] HALTED_V  = 8'b1101_0101;
    localparam logic [7:0] TO_V      = 8'b0000_0010;

    logic             clk;
    logic             rst_b;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_src1_used;
    logic             id_src2_used;
    logic             id_halted;
    logic [REG_W-1:0] ex_dest_reg_num;
    logic             ex_reg_write;
    logic             ex_mem_to_reg;
    logic             ex_jump_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_freeze;
    logic             if_id_freeze;
    logic             if_id_flush;
    logic             id_exe_freeze;
    logic             id_exe_bubble;
    logic             exe_mem_freeze;
    logic             mem_timeout;
    logic             halted;
    logic [7:0]       outs;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: halt bookkeeping in cycles, stall run length, sticky timeout.
    bit m_drain;
    bit m_halted;
    bit m_timeout;
    int m_drain_left;
    int m_stall_run;

    pipeline_hazard_ctrl #(
        .REG_W        (REG_W),
        .MEM_TIMEOUT  (MEM_TIMEOUT),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_src1_used    (id_src1_used),
        .id_src2_used    (id_src2_used),
        .id_halted       (id_halted),
        .ex_dest_reg_num (ex_dest_reg_num),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_jump_taken   (ex_jump_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_freeze       (pc_freeze),
        .if_id_freeze    (if_id_freeze),
        .if_id_flush     (if_id_flush),
        .id_exe_freeze   (id_exe_freeze),
        .id_exe_bubble   (id_exe_bubble),
        .exe_mem_freeze  (exe_mem_freeze),
        .mem_timeout     (mem_timeout),
        .halted          (halted)
    );

    assign outs = {pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze,
                   id_exe_bubble, exe_mem_freeze, mem_timeout, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_lu();
        bit hit1;
        bit hit2;
        hit1 = id_src1_used && (id_src1 == ex_dest_reg_num);
        hit2 = id_src2_used && (id_src2 == ex_dest_reg_num);
        return ex_mem_to_reg && ex_reg_write && (ex_dest_reg_num != 5'd0) && (hit1 || hit2);
    endfunction

    function automatic logic [7:0] model_out();
        logic [7:0] v;
        bit stall;
        stall = mem_req && !mem_ready;
        if (!rst_b)              v = NONE_V;
        else if (m_halted)       v = HALTED_V;
        else if (stall)          v = STALL_V;
        else if (m_drain)        v = DRAIN_V;
        else if (ex_jump_taken)  v = JUMP_V;
        else if (model_lu())     v = LU_V;
        else if (id_halted)      v = HALTDET_V;
        else                     v = NONE_V;
        if (rst_b && m_timeout) v = v | TO_V;
        return v;
    endfunction

    task automatic model_update();
        bit stall;
        stall = mem_req && !mem_ready;
        if (!rst_b) begin
            m_drain = 1'b0; m_halted = 1'b0; m_timeout = 1'b0;
            m_drain_left = 0; m_stall_run = 0;
        end else if (!m_halted) begin
            if (m_stall_run >= MEM_TIMEOUT) m_timeout = 1'b1;
            if (stall) begin
                m_stall_run++;
            end else begin
                m_stall_run = 0;
                if (m_drain) begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_halted = 1'b1;
                end else if (!ex_jump_taken && !model_lu() && id_halted) begin
                    m_drain      = 1'b1;
                    m_drain_left = DRAIN_CYCLES - 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic sample(input string tag);
        @(negedge clk);
        chk(tag, outs, model_out());
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        id_src1 = '0; id_src2 = '0; id_src1_used = 1'b0; id_src2_used = 1'b0;
        id_halted = 1'b0; ex_dest_reg_num = '0; ex_reg_write = 1'b0;
        ex_mem_to_reg = 1'b0; ex_jump_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic set_ex(input logic [REG_W-1:0] dest, input logic wr, input logic ld);
        ex_dest_reg_num = dest; ex_reg_write = wr; ex_mem_to_reg = ld;
    endtask

    task automatic set_id(input logic [REG_W-1:0] s1, input logic u1,
                          input logic [REG_W-1:0] s2, input logic u2);
        id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
    endtask

    task automatic directed(input string tag, input logic [7:0] want);
        sample(tag);
        chk({tag, "_const"}, outs, want);
        advance();
    endtask

    task automatic reset_pulse(input string tag);
        rst_b = 1'b0;
        directed(tag, NONE_V);
        rst_b = 1'b1;
    endtask

    initial begin
        idle();
        rst_b = 1'b0;
        set_ex(5'd5, 1'b1, 1'b1);
        set_id(5'd5, 1'b1, 5'd5, 1'b1);
        directed("reset_outs", NONE_V);
        rst_b = 1'b1;
        idle();

        // load-use on src1, then the bubble has cleared EXE
        set_ex(5'd5, 1'b1, 1'b1); set_id(5'd5, 1'b1, 5'd2, 1'b1);
        directed("lu_src1", LU_V);
        set_ex(5'd0, 1'b0, 1'b0);
        directed("lu_after", NONE_V);
        set_ex(5'd0, 1'b1, 1'b1); set_id(5'd0, 1'b1, 5'd0, 1'b1);
        directed("lu_dest0", NONE_V);
        set_ex(5'd5, 1'b1, 1'b0); set_id(5'd5, 1'b1, 5'd2, 1'b1);
        directed("lu_not_load", NONE_V);
        set_ex(5'd5, 1'b1, 1'b1); set_id(5'd3, 1'b1, 5'd5, 1'b0);
        directed("lu_src2_unused", NONE_V);
        set_id(5'd3, 1'b1, 5'd5, 1'b1);
        directed("lu_src2", LU_V);
        idle();

        // 4-cycle cache miss, jump in the first cycle loses to the stall
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ex_jump_taken = (i == 0);
            directed("mem_stall", STALL_V);
        end
        ex_jump_taken = 1'b0; mem_ready = 1'b1;
        directed("mem_release", NONE_V);
        idle();

        // long miss: timeout after 64 MEM_WAIT cycles, sticky until reset
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int j = 0; j < 70; j++) begin
            sample("to_run");
            if (j == 64) chk("to_not_yet", outs, STALL_V);
            if (j == 65) chk("to_rise", outs, STALL_V | TO_V);
            advance();
        end
        idle();
        directed("to_sticky", TO_V);
        reset_pulse("to_reset");
        directed("to_cleared", NONE_V);

        // jump beats load-use and halt
        set_ex(5'd5, 1'b1, 1'b1); set_id(5'd5, 1'b1, 5'd0, 1'b0); ex_jump_taken = 1'b1;
        directed("jump_over_lu", JUMP_V);
        idle(); ex_jump_taken = 1'b1; id_halted = 1'b1;
        directed("jump_over_halt", JUMP_V);
        idle();
        directed("halt_ignored", NONE_V);

        // halt drains in 3 cycles, jump ignored while draining, halted is terminal
        id_halted = 1'b1;
        directed("halt_detect", HALTDET_V);
        idle(); ex_jump_taken = 1'b1;
        directed("drain1_jump", DRAIN_V);
        idle();
        directed("drain2", DRAIN_V);
        directed("halted_at_3", HALTED_V);
        mem_req = 1'b1; set_ex(5'd5, 1'b1, 1'b1); set_id(5'd5, 1'b1, 5'd0, 1'b0);
        directed("halted_terminal", HALTED_V);
        idle();
        reset_pulse("halt_reset");

        // 2-cycle stall during drain pushes halted to 5 cycles
        id_halted = 1'b1;
        directed("halt2_detect", HALTDET_V);
        idle(); mem_req = 1'b1;
        directed("drain_stall1", STALL_V);
        directed("drain_stall2", STALL_V);
        mem_ready = 1'b1;
        directed("drain_release", DRAIN_V);
        idle();
        directed("drain_last", DRAIN_V);
        directed("halted_at_5", HALTED_V);
        reset_pulse("halt2_reset");

        // reset in the middle of a drain returns to normal running
        id_halted = 1'b1;
        directed("halt3_detect", HALTDET_V);
        idle();
        directed("halt3_drain", DRAIN_V);
        reset_pulse("drain_reset");
        directed("post_reset_idle", NONE_V);
        set_ex(5'd4, 1'b1, 1'b1); set_id(5'd4, 1'b1, 5'd0, 1'b0);
        directed("post_reset_lu", LU_V);
        idle();

        for (int k = 0; k < 400; k++) begin
            id_src1         = REG_W'($urandom_range(0, 3));
            id_src2         = REG_W'($urandom_range(0, 3));
            ex_dest_reg_num = REG_W'($urandom_range(0, 3));
            id_src1_used    = ($urandom_range(0, 1) == 1);
            id_src2_used    = ($urandom_range(0, 1) == 1);
            ex_reg_write    = ($urandom_range(0, 3) != 0);
            ex_mem_to_reg   = ($urandom_range(0, 1) == 1);
            ex_jump_taken   = ($urandom_range(0, 7) == 0);
            id_halted       = ($urandom_range(0, 29) == 0);
            mem_req         = ($urandom_range(0, 3) == 0);
            mem_ready       = ($urandom_range(0, 1) == 1);
            if ((m_halted && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 99) == 0)) begin
                reset_pulse("rand_reset");
            end else begin
                sample("rand");
                advance();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
